// File: rtl/adjust_key_repeater.sv
// Key conditioner for the time/alarm adjust path: per-line synchroniser,
// debouncer and press/auto-repeat step generator running on the scan clock.
module adjust_key_repeater #(
   parameter int unsigned N             = 6,
   parameter int unsigned DEBOUNCE      = 200,
   parameter int unsigned REPEAT_DELAY  = 5000,
   parameter int unsigned REPEAT_PERIOD = 2000
) (
   input  logic         clock,
   input  logic         rst,
   input  logic         en,
   input  logic [N-1:0] keys,
   output logic [N-1:0] level,
   output logic [N-1:0] step,
   output logic         any_held
);

   localparam int unsigned CW   = $clog2(DEBOUNCE + 1);
   localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RW   = $clog2(RMAX + 1);

   localparam logic [CW-1:0] DB_TC = CW'(DEBOUNCE - 1);
   localparam logic [RW-1:0] RD_TC = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RP_TC = RW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DELAY   = 2'd1,
      REPEAT  = 2'd2,
      BLOCKED = 2'd3
   } state_t;

   logic [N-1:0] nlevel_c;
   logic         any_held_q;

   for (genvar i = 0; i < int'(N); i++) begin : g_line
      logic          s1_q;
      logic          s2_q;
      logic          level_q;
      logic          level_d;
      logic          step_q;
      logic          step_d;
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic [RW-1:0] rcnt_q;
      logic [RW-1:0] rcnt_d;
      state_t        state_q;
      state_t        state_d;

      always_ff @(posedge clock or negedge rst) begin
         if (!rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            step_q  <= 1'b0;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            state_q <= IDLE;
         end else begin
            s1_q    <= keys[i];
            s2_q    <= s1_q;
            level_q <= level_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            state_q <= state_d;
         end
      end

      // Debounce: any sample equal to the current level restarts the count.
      always_comb begin
         level_d = level_q;
         cnt_d   = '0;
         if (s2_q != level_q) begin
            if (cnt_q == DB_TC) begin
               level_d = s2_q;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      end

      // Step FSM works on the incoming level so a release cancels a same-edge step.
      always_comb begin
         state_d = state_q;
         rcnt_d  = rcnt_q;
         step_d  = 1'b0;
         case (state_q)
            IDLE: begin
               rcnt_d = '0;
               if (level_d) begin
                  if (en) begin
                     step_d  = 1'b1;
                     state_d = DELAY;
                  end else begin
                     state_d = BLOCKED;
                  end
               end
            end
            DELAY: begin
               if (!level_d) begin
                  rcnt_d  = '0;
                  state_d = IDLE;
               end else if (!en) begin
                  rcnt_d  = '0;
                  state_d = BLOCKED;
               end else if (rcnt_q == RD_TC) begin
                  step_d  = 1'b1;
                  rcnt_d  = '0;
                  state_d = REPEAT;
               end else begin
                  rcnt_d = rcnt_q + RW'(1);
               end
            end
            REPEAT: begin
               if (!level_d) begin
                  rcnt_d  = '0;
                  state_d = IDLE;
               end else if (!en) begin
                  rcnt_d  = '0;
                  state_d = BLOCKED;
               end else if (rcnt_q == RP_TC) begin
                  step_d = 1'b1;
                  rcnt_d = '0;
               end else begin
                  rcnt_d = rcnt_q + RW'(1);
               end
            end
            BLOCKED: begin
               rcnt_d = '0;
               if (!level_d) begin
                  state_d = IDLE;
               end
            end
            default: begin
               rcnt_d  = '0;
               state_d = IDLE;
            end
         endcase
      end

      assign level[i]    = level_q;
      assign step[i]     = step_q;
      assign nlevel_c[i] = level_d;
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         any_held_q <= 1'b0;
      end else begin
         any_held_q <= |nlevel_c;
      end
   end

   assign any_held = any_held_q;

endmodule

// File: tb/tb_adjust_key_repeater.sv
// Bench for adjust_key_repeater: directed scenarios plus random key/enable
// traffic, each cycle checked against an edge-count reference model.
module tb_adjust_key_repeater;

   localparam int N  = 6;
   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RP = 5;

   logic         clock = 1'b0;
   logic         rst   = 1'b0;
   logic         en    = 1'b0;
   logic [N-1:0] keys  = '0;
   logic [N-1:0] level;
   logic [N-1:0] step;
   logic         any_held;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   adjust_key_repeater #(
      .N            (N),
      .DEBOUNCE     (DB),
      .REPEAT_DELAY (RD),
      .REPEAT_PERIOD(RP)
   ) dut (
      .clock   (clock),
      .rst     (rst),
      .en      (en),
      .keys    (keys),
      .level   (level),
      .step    (step),
      .any_held(any_held)
   );

   // Reference model: key samples pass a two-edge delay, level flips after DB
   // consecutive differing samples, steps at E, E+RD, E+RD+k*RP while armed.
   logic [N-1:0] m_d1, m_d2, m_level, m_step, m_active;
   logic         m_any;
   int           m_run [N];
   int           m_e   [N];
   int           m_t;

   task automatic model_reset();
      m_d1 = '0; m_d2 = '0; m_level = '0; m_step = '0; m_active = '0; m_any = 1'b0;
      for (int i = 0; i < N; i++) begin
         m_run[i] = 0;
         m_e[i]   = 0;
      end
   endtask

   task automatic model_step();
      logic [N-1:0] sv;
      logic nl, st;
      int dt;
      sv   = m_d2;
      m_d2 = m_d1;
      m_d1 = keys;
      for (int i = 0; i < N; i++) begin
         nl = m_level[i];
         if (sv[i] != m_level[i]) begin
            m_run[i]++;
            if (m_run[i] == DB) begin
               nl = ~nl;
               m_run[i] = 0;
            end
         end else begin
            m_run[i] = 0;
         end
         st = 1'b0;
         if (!nl) begin
            m_active[i] = 1'b0;
         end else if (!m_level[i]) begin
            m_active[i] = en;
            st = en;
            m_e[i] = m_t;
         end else if (!en) begin
            m_active[i] = 1'b0;
         end else if (m_active[i]) begin
            dt = m_t - m_e[i];
            st = (dt == RD) || (dt > RD && ((dt - RD) % RP) == 0);
         end
         m_level[i] = nl;
         m_step[i]  = st;
      end
      m_any = |m_level;
      m_t++;
   endtask

   task automatic tick();
      @(posedge clock);
      if (!rst) model_reset();
      else      model_step();
      @(negedge clock);
   endtask

   task automatic wait_step(input int ln, output int lat);
      lat = -1;
      for (int c = 0; c < 40 && lat < 0; c++) begin
         tick();
         if (step[ln]) lat = c;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; en = 1'b0; keys = '0;
      model_reset();
      m_t = 0;
      repeat (3) tick();
      n_cmp++;
      if ({level, step, any_held} !== '0) begin
         n_fail++;
         $display("FAIL reset_state got level=%b step=%b any=%b exp all 0", level, step, any_held);
      end
      rst = 1'b1; en = 1'b1;
      tick();
      n_cmp++;
      if ({level, step, any_held} !== {m_level, m_step, m_any}) begin
         n_fail++;
         $display("FAIL reset_release got %b exp %b", {level, step, any_held}, {m_level, m_step, m_any});
      end
   endtask

   task automatic test_debounce();
      logic lv, st;
      keys[0] = 1'b1;
      for (int c = 0; c < 12; c++) begin
         tick();
         lv = (c >= DB + 1);
         st = (c == DB + 1);
         n_cmp++;
         if ({level[0], step[0], any_held} !== {lv, st, lv}) begin
            n_fail++;
            $display("FAIL debounce_edge%0d got lvl/step/any=%b%b%b exp %b%b%b", c, level[0], step[0], any_held, lv, st, lv);
         end
         n_cmp++;
         if ({level, step, any_held} !== {m_level, m_step, m_any}) begin
            n_fail++;
            $display("FAIL debounce_model c=%0d got %b exp %b", c, {level, step, any_held}, {m_level, m_step, m_any});
         end
      end
      keys[0] = 1'b0;
      repeat (10) begin
         tick();
         n_cmp++;
         if ({level, step, any_held} !== {m_level, m_step, m_any}) begin
            n_fail++;
            $display("FAIL debounce_release_model got %b exp %b", {level, step, any_held}, {m_level, m_step, m_any});
         end
      end
   endtask

   task automatic test_glitch();
      for (int c = 0; c < 14; c++) begin
         keys[1] = (c < 3);
         tick();
         n_cmp++;
         if ({level[1], step[1], any_held} !== 3'b000) begin
            n_fail++;
            $display("FAIL glitch c=%0d got lvl/step/any=%b%b%b exp 000", c, level[1], step[1], any_held);
         end
      end
   endtask

   task automatic test_auto_repeat();
      int lat, fall, g;
      int got[$];
      keys[2] = 1'b1;
      wait_step(2, lat);
      n_cmp++;
      if (lat != DB + 1) begin
         n_fail++;
         $display("FAIL repeat_first_latency got %0d exp %0d", lat, DB + 1);
      end
      fall = -1;
      for (int k = 1; k <= 55; k++) begin
         tick();
         n_cmp++;
         if ({level, step, any_held} !== {m_level, m_step, m_any}) begin
            n_fail++;
            $display("FAIL repeat_model k=%0d got %b exp %b", k, {level, step, any_held}, {m_level, m_step, m_any});
         end
         if (step[2]) got.push_back(k);
         if (fall < 0 && !level[2]) fall = k;
         if (k == 39) keys[2] = 1'b0;
      end
      n_cmp++;
      if (got.size() != 7) begin
         n_fail++;
         $display("FAIL repeat_count got %0d exp 7", got.size());
      end
      for (int j = 0; j < 7; j++) begin
         g = (j < got.size()) ? got[j] : -1;
         n_cmp++;
         if (g != RD + RP * j) begin
            n_fail++;
            $display("FAIL repeat_step%0d got E+%0d exp E+%0d", j, g, RD + RP * j);
         end
      end
      n_cmp++;
      if (fall != 45) begin
         n_fail++;
         $display("FAIL repeat_level_fall got E+%0d exp E+45", fall);
      end
   endtask

   task automatic test_release_race();
      int lat;
      keys[3] = 1'b1;
      wait_step(3, lat);
      n_cmp++;
      if (lat != DB + 1) begin
         n_fail++;
         $display("FAIL race_first_latency got %0d exp %0d", lat, DB + 1);
      end
      repeat (4) tick();
      keys[3] = 1'b0;
      for (int k = 5; k <= 16; k++) begin
         tick();
         n_cmp++;
         if ({level[3], step[3]} !== {(k < RD), 1'b0}) begin
            n_fail++;
            $display("FAIL race_E+%0d got lvl/step=%b%b exp %b0", k, level[3], step[3], (k < RD));
         end
      end
      keys[3] = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         n_cmp++;
         if (step[3] !== (c == DB + 1)) begin
            n_fail++;
            $display("FAIL race_repress c=%0d got step=%b exp %b", c, step[3], (c == DB + 1));
         end
      end
      keys[3] = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_enable_gating();
      int lat;
      keys[4] = 1'b1;
      wait_step(4, lat);
      n_cmp++;
      if (lat != DB + 1) begin
         n_fail++;
         $display("FAIL gate_first_latency got %0d exp %0d", lat, DB + 1);
      end
      repeat (2) tick();
      en = 1'b0;
      for (int k = 0; k < 36; k++) begin
         if (k == 18) en = 1'b1;
         tick();
         n_cmp++;
         if ({level[4], step[4]} !== 2'b10) begin
            n_fail++;
            $display("FAIL gate_held k=%0d en=%b got lvl/step=%b%b exp 10", k, en, level[4], step[4]);
         end
      end
      keys[4] = 1'b0;
      repeat (10) begin
         tick();
         n_cmp++;
         if ({level, step, any_held} !== {m_level, m_step, m_any}) begin
            n_fail++;
            $display("FAIL gate_release_model got %b exp %b", {level, step, any_held}, {m_level, m_step, m_any});
         end
      end
      keys[4] = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         n_cmp++;
         if (step[4] !== (c == DB + 1)) begin
            n_fail++;
            $display("FAIL gate_repress c=%0d got step=%b exp %b", c, step[4], (c == DB + 1));
         end
      end
      keys[4] = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_async_reset();
      int lat;
      keys[5] = 1'b1;
      wait_step(5, lat);
      repeat (15) tick();
      n_cmp++;
      if ({level[5], step[5], any_held} !== 3'b111) begin
         n_fail++;
         $display("FAIL areset_pre got lvl/step/any=%b%b%b exp 111", level[5], step[5], any_held);
      end
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if ({level, step, any_held} !== '0) begin
         n_fail++;
         $display("FAIL areset_immediate got level=%b step=%b any=%b exp all 0", level, step, any_held);
      end
      repeat (2) tick();
      rst = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         n_cmp++;
         if ({level[5], step[5]} !== {(c >= DB + 1), (c == DB + 1)}) begin
            n_fail++;
            $display("FAIL areset_restart c=%0d got lvl/step=%b%b exp %b%b", c, level[5], step[5], (c >= DB + 1), (c == DB + 1));
         end
         n_cmp++;
         if ({level, step, any_held} !== {m_level, m_step, m_any}) begin
            n_fail++;
            $display("FAIL areset_model c=%0d got %b exp %b", c, {level, step, any_held}, {m_level, m_step, m_any});
         end
      end
      keys[5] = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_random();
      int hold [N];
      for (int i = 0; i < N; i++) hold[i] = int'($urandom_range(1, 30));
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            hold[i]--;
            if (hold[i] == 0) begin
               keys[i] = ~keys[i];
               hold[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5)) : int'($urandom_range(5, 45));
            end
         end
         if ($urandom_range(0, 99) == 0) en = ~en;
         tick();
         n_cmp++;
         if ({level, step, any_held} !== {m_level, m_step, m_any}) begin
            n_fail++;
            $display("FAIL random_model c=%0d got %b exp %b", c, {level, step, any_held}, {m_level, m_step, m_any});
         end
      end
      keys = '0;
      en   = 1'b1;
      repeat (12) begin
         tick();
         n_cmp++;
         if ({level, step, any_held} !== {m_level, m_step, m_any}) begin
            n_fail++;
            $display("FAIL random_drain got %b exp %b", {level, step, any_held}, {m_level, m_step, m_any});
         end
      end
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_glitch();
      test_auto_repeat();
      test_release_race();
      test_enable_gating();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/adjust_key_repeater.md
# adjust_key_repeater

Conditions the raw board switches/keys used for time adjustment and alarm setting (hour/minute/second tens and units lines) before they reach the clock's adjust registers. Per line, it synchronises the raw input, debounces it, and turns each press into a single-cycle `step` pulse. Holding a key auto-repeats the pulse after an initial delay. It runs on the 10 kHz scan clock and replaces the free-running 1 Hz increment of the adjust path: the downstream adjust counters add one unit per `step` pulse.

## Interface
- `N`, 6: number of independent key lines.
- `DEBOUNCE`, 200: cycles a synchronised input must differ stably from `level` before `level` flips (≥1).
- `REPEAT_DELAY`, 5000: cycles from the first step to the first repeat step (≥1).
- `REPEAT_PERIOD`, 2000: cycles between subsequent repeat steps (≥1).
- `clock`  in  1  sampling clock (10 kHz in the system).
- `rst`  in  1  reset, asynchronous, active-low.
- `en`  in  1  step enable; 0 suppresses all steps.
- `keys`  in  N  raw asynchronous key/switch levels, 1 = pressed.
- `level`  out  N  debounced key levels.
- `step`  out  N  one-cycle step pulses.
- `any_held`  out  1  OR-reduction of `level`.

## Operation
- Each line is fully independent. The per-line logic is replicated, and there is no priority between lines. Tens-over-units priority stays downstream.
- Synchroniser: 2 flops, `s1 <= keys[i]`, `s2 <= s1`.
- Debounce counter, width `$clog2(DEBOUNCE+1)`:
  - If `s2 == level`, then `cnt <= 0`.
  - Else if `cnt == DEBOUNCE-1`, then `level <= s2` and `cnt <= 0`.
  - Else `cnt <= cnt+1`.
  - Any bounce back to `level` restarts the count.
- `nlevel` is the value `level` takes on the current edge. The FSM evaluates on `nlevel`, so it reacts on the same edge `level` changes.
- Per-line FSM, states IDLE, DELAY, REPEAT, BLOCKED. Repeat counter width is `$clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1)`.
  - IDLE:
    - `nlevel=1` and `en=1`: `step=1`, `rcnt<=0`, go to DELAY.
    - `nlevel=1` and `en=0`: go to BLOCKED.
  - DELAY:
    - `nlevel=0`: go to IDLE.
    - `en=0`: go to BLOCKED.
    - `rcnt == REPEAT_DELAY-1`: `step=1`, `rcnt<=0`, go to REPEAT.
    - Otherwise `rcnt++`.
  - REPEAT: same as DELAY, but uses `REPEAT_PERIOD-1`, and on terminal count stays in REPEAT.
  - BLOCKED: `nlevel=0` goes to IDLE. No steps. A key held while `en` was low must be released and re-pressed before stepping.
- `step` is registered and is high for exactly one cycle per event.
- No step is ever emitted on or after the edge where `level` falls.

## Timing
- Reset values: `s1`, `s2`, `level`, `step`, `any_held`, and all counters are 0. All FSMs are in IDLE.
- Raw-to-level latency, with edge 0 being the first rising edge after `keys[i]` changes and the input stable: `level` updates on edge `DEBOUNCE+1`.
- First `step` is on the same edge as the `level` rise.
- Repeat steps land at edge E+`REPEAT_DELAY`, then E+`REPEAT_DELAY`+k·`REPEAT_PERIOD` for k ≥ 1, where E is the first step edge.
- `any_held` is registered on the same edge as `level`.
- Input pulse of ≤ `DEBOUNCE`-1 cycles at `s2`: no `level` change and no step.
- `en` falling while in DELAY or REPEAT: `step` is 0 from that edge onward.
- `en` rising while a key is held: no step until release and re-press.
- Reset asserted mid-repeat: all outputs go to 0 immediately (asynchronous). After release, a key still held produces a fresh first step only after a full debounce from edge 0.
- Counters never wrap. Terminal-count compares reset them.

## Test plan
- Debounce (`DEBOUNCE=4`, `REPEAT_DELAY=10`, `REPEAT_PERIOD=5`, `en=1`): raise `keys[0]` before edge 0 and hold. `level[0]` and `step[0]` rise on edge 5. `step[0]` is high for 1 cycle. `any_held=1`.
- Glitch: 3-cycle high pulse on `keys[1]`. `level[1]`, `step[1]`, and `any_held` stay 0 throughout.
- Auto-repeat: hold `keys[2]` for 40 cycles past its first step at edge E. Steps occur at E, E+10, E+15, E+20, E+25, E+30, E+35, E+40. No step on the edge `level[2]` falls.
- Release race: release `keys[3]` so that `level` falls on the edge the DELAY terminal count would fire. No step is emitted and the FSM is in IDLE.
- Enable gating: hold `keys[4]` and drop `en` at E+3. No steps follow. Raise `en` while still held: no steps. Release, then re-press: a step occurs after debounce.
- Async reset mid-REPEAT on `keys[5]`: all outputs are 0 within the reset cycle. Keep the key held through reset release: the next step arrives on edge `DEBOUNCE+1` after reset deasserts.
